// File: rtl/usb_packet_tx_framer_pkg.sv
// Shared USB packet types and constants for the transmit framer and CRC helpers.
package usb_packet_tx_framer_pkg;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_SOF   = 4'b0101,
        PID_SETUP = 4'b1101,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_ACK   = 4'b0010,
        PID_NACK  = 4'b1010,
        PID_STALL = 4'b1110
    } PID_Types;

    // PID byte on the wire: check nibble (complement) in the upper half.
    typedef struct packed {
        logic [3:0] pidCheck;
        logic [3:0] pid;
    } PacketHeader;

    localparam logic [15:0] CRC16_INIT           = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY_REFLECTED = 16'hA001;

    typedef enum logic [2:0] {
        IDLE,
        SEND_PID,
        SEND_DATA,
        SEND_CRC_LO,
        SEND_CRC_HI,
        DONE
    } TxFramerState;

    function automatic logic isHandshakePid(input logic [3:0] pid);
        return (pid == PID_ACK) || (pid == PID_NACK) || (pid == PID_STALL);
    endfunction

    function automatic logic isDataPid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

    function automatic PacketHeader makeHeader(input logic [3:0] pid);
        PacketHeader h;
        h.pidCheck = ~pid;
        h.pid      = pid;
        return h;
    endfunction

endpackage

// File: rtl/usb_packet_tx_framer_if.sv
// Request, payload and serializer-side handshake signals of the TX framer.
interface usb_packet_tx_framer_if;
    logic       txReqSendPacket;
    logic [3:0] txReqPid;
    logic       txReqNoPayload;
    logic       txReqAccepted;
    logic       txReqError;
    logic       txBusy;
    logic       txDone;
    logic       txDataValid;
    logic [7:0] txDataByte;
    logic       txDataIsLast;
    logic       txDataReady;
    logic       txOutValid;
    logic [7:0] txOutByte;
    logic       txOutLast;
    logic       txOutReady;

    // Endpoint / serializer environment side.
    modport master (
        output txReqSendPacket, txReqPid, txReqNoPayload,
        output txDataValid, txDataByte, txDataIsLast, txOutReady,
        input  txReqAccepted, txReqError, txBusy, txDone,
        input  txDataReady, txOutValid, txOutByte, txOutLast
    );

    // Framer side.
    modport slave (
        input  txReqSendPacket, txReqPid, txReqNoPayload,
        input  txDataValid, txDataByte, txDataIsLast, txOutReady,
        output txReqAccepted, txReqError, txBusy, txDone,
        output txDataReady, txOutValid, txOutByte, txOutLast
    );
endinterface

// File: rtl/usb_packet_tx_framer_crc16.sv
// Combinational USB CRC16 byte update (reflected, LSb first); shared with RX CRC check.
module usb_crc16_byte
    import usb_packet_tx_framer_pkg::*;
(
    input  logic [15:0] crcIn,
    input  logic [7:0]  dataIn,
    output logic [15:0] crcOut
);
    // Eight reflected shift/xor steps, one per data bit.
    always_comb begin
        crcOut = crcIn ^ {8'h00, dataIn};
        for (int unsigned i = 0; i < 8; i++) begin
            crcOut = crcOut[0] ? ((crcOut >> 1) ^ CRC16_POLY_REFLECTED) : (crcOut >> 1);
        end
    end
endmodule

// File: rtl/usb_packet_tx_framer.sv
// Device-side TX framer: PID byte, optional payload, CRC16 to the bit serializer.
module usb_packet_tx_framer
    import usb_packet_tx_framer_pkg::*;
(
    input  logic                 clk48,
    input  logic                 rst,
    usb_packet_tx_framer_if.slave bus
);
    TxFramerState state, stateNext;
    logic [3:0]  pidReg;
    logic        noPayloadReg;
    logic [15:0] crcReg;
    logic [15:0] crcNext;
    logic        regValid;
    logic [7:0]  regByte;
    logic        regLast;

    logic        reqAccepted, reqError, busy, done, dataReady, consume;
    logic        outValid, outLast;
    logic [7:0]  outByte;

    usb_crc16_byte crcUnit (
        .crcIn  (crcReg),
        .dataIn (bus.txDataByte),
        .crcOut (crcNext)
    );

    // State register.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Next-state decode and all handshake/output signals.
    always_comb begin
        stateNext   = state;
        reqAccepted = 1'b0;
        reqError    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        dataReady   = 1'b0;
        consume     = 1'b0;
        outValid    = 1'b0;
        outByte     = '0;
        outLast     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.txReqSendPacket) begin
                    if (isDataPid(bus.txReqPid) || isHandshakePid(bus.txReqPid)) begin
                        reqAccepted = 1'b1;
                        stateNext   = SEND_PID;
                    end else begin
                        reqError = 1'b1;
                    end
                end
            end
            SEND_PID: begin
                busy     = 1'b1;
                outValid = 1'b1;
                outByte  = makeHeader(pidReg);
                outLast  = isHandshakePid(pidReg);
                if (bus.txOutReady) begin
                    if (isHandshakePid(pidReg)) stateNext = DONE;
                    else if (noPayloadReg)      stateNext = SEND_CRC_LO;
                    else                        stateNext = SEND_DATA;
                end
            end
            SEND_DATA: begin
                busy      = 1'b1;
                // A held final byte blocks further payload until it leaves.
                dataReady = !regValid || (bus.txOutReady && !regLast);
                consume   = bus.txDataValid && dataReady;
                // Empty register passes the incoming byte straight through so
                // PID->data and data->data need no bubble cycle.
                if (regValid) begin
                    outValid = 1'b1;
                    outByte  = regByte;
                    if (bus.txOutReady && regLast) stateNext = SEND_CRC_LO;
                end else if (bus.txDataValid) begin
                    outValid = 1'b1;
                    outByte  = bus.txDataByte;
                    if (bus.txOutReady && bus.txDataIsLast) stateNext = SEND_CRC_LO;
                end
            end
            SEND_CRC_LO: begin
                busy     = 1'b1;
                outValid = 1'b1;
                outByte  = ~crcReg[7:0];
                if (bus.txOutReady) stateNext = SEND_CRC_HI;
            end
            SEND_CRC_HI: begin
                busy     = 1'b1;
                outValid = 1'b1;
                outByte  = ~crcReg[15:8];
                outLast  = 1'b1;
                if (bus.txOutReady) stateNext = DONE;
            end
            DONE: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Request latch, running CRC and the one-entry payload output register.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            pidReg       <= '0;
            noPayloadReg <= 1'b0;
            crcReg       <= CRC16_INIT;
            regValid     <= 1'b0;
            regByte      <= '0;
            regLast      <= 1'b0;
        end else begin
            if (reqAccepted) begin
                pidReg       <= bus.txReqPid;
                noPayloadReg <= bus.txReqNoPayload;
                crcReg       <= CRC16_INIT;
                regValid     <= 1'b0;
            end
            if (consume) begin
                crcReg <= crcNext;
                // Bypassed byte taken downstream this cycle leaves the register empty.
                if (regValid || !bus.txOutReady) begin
                    regValid <= 1'b1;
                    regByte  <= bus.txDataByte;
                    regLast  <= bus.txDataIsLast;
                end
            end else if (state == SEND_DATA && regValid && bus.txOutReady) begin
                regValid <= 1'b0;
            end
        end
    end

    assign bus.txReqAccepted = reqAccepted;
    assign bus.txReqError    = reqError;
    assign bus.txBusy        = busy;
    assign bus.txDone        = done;
    assign bus.txDataReady   = dataReady;
    assign bus.txOutValid    = outValid;
    assign bus.txOutByte     = outByte;
    assign bus.txOutLast     = outLast;
endmodule

// File: doc/usb_packet_tx_framer.md
# usb_packet_tx_framer

- Device-side transmit framer: turns a request to send a handshake or data packet into the byte stream the bit-level TX serializer sends LSb first.
- Output stream per packet:
  - PID byte, in PacketHeader layout.
  - For data packets: payload bytes pulled from the endpoint buffer, then the two CRC16 bytes.
- Sits between the endpoint/transaction logic and the NRZI/bit-stuffing serializer.
- It is the transmit counterpart to the receive-side token/SOF packet decoding.

## Interface
Parameters: none.

Ports:
- clk48  in  1  single clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- txReqSendPacket  in  1  request strobe, sampled in IDLE only
- txReqPid  in  4  PID_Types; DATA0/DATA1/ACK/NACK/STALL accepted
- txReqNoPayload  in  1  data packet has zero-length payload (ZLP)
- txReqAccepted  out  1  one-cycle pulse, request taken
- txReqError  out  1  one-cycle pulse, request with unsupported PID dropped
- txBusy  out  1  high from cycle after accept until done
- txDone  out  1  one-cycle pulse after last byte handshake
- txDataValid  in  1  payload byte available
- txDataByte  in  8  payload byte
- txDataIsLast  in  1  qualifies txDataByte as final payload byte
- txDataReady  out  1  payload byte consumed this cycle
- txOutValid  out  1  txOutByte valid
- txOutByte  out  8  byte to serializer
- txOutLast  out  1  txOutByte is final byte of packet (EOP follows)
- txOutReady  in  1  serializer accepts byte

## Operation
- States: IDLE, SEND_PID, SEND_DATA, SEND_CRC_LO, SEND_CRC_HI, DONE.
- Request acceptance (IDLE only):
  - IDLE + txReqSendPacket + PID in {DATA0, DATA1, ACK, NACK, STALL}: latch PID and NoPayload, pulse txReqAccepted, go to SEND_PID.
  - Any other PID: pulse txReqError, stay in IDLE.
- SEND_PID: txOutByte = {~pid, pid}; txOutLast = 1 for handshakes. On handshake, next state:
  - Handshake PIDs: DONE.
  - NoPayload: SEND_CRC_LO.
  - Otherwise: SEND_DATA.
- SEND_DATA: txOutByte/txOutValid come from a one-entry output register.
  - txDataReady = register empty, or register being accepted this cycle.
  - Each consumed byte updates the CRC and loads the register.
  - After the byte with txDataIsLast is accepted downstream, go to SEND_CRC_LO.
- CRC16: USB CRC16, reflected poly 0xA001, init 0xFFFF, one byte per update.
  - Init at accept.
  - Transmitted value = ~crc, low byte first (SEND_CRC_LO), then high byte (SEND_CRC_HI, txOutLast = 1).
- DONE: pulse txDone, go to IDLE.
- Requests while busy are ignored (no accept, no error pulse).

## Timing
- Reset: state IDLE, CRC 0xFFFF, output register empty; all outputs 0.
- Reset mid-packet aborts immediately; no txDone.
- Accept cycle N → txBusy and txOutValid (PID) high at N+1.
- Output byte handshake = txOutValid & txOutReady. txOutByte/txOutLast hold stable while valid & !ready.
- Zero-bubble streaming: with txDataValid and txOutReady continuously high, one byte per cycle, including PID→data and data→CRC transitions.
- txDataReady never asserts outside SEND_DATA.
- txDataValid & txDataIsLast consumed together with txOutReady in the same cycle: CRC_LO becomes valid the cycle after the last data byte is accepted.
- txDone pulses the cycle after the last byte handshake; txBusy falls in that same cycle.
- A new request is accepted no earlier than the cycle after txDone.

## Structure
- Additions to usb_packet_pkg:
  - CRC16_INIT = 16'hFFFF
  - CRC16_POLY_REFLECTED = 16'hA001
  - typedef enum TxFramerState
- Sub-module usb_crc16_byte: combinational next-CRC from (crc, byte). Reusable by the RX CRC check.

## Test plan
- ACK request → single byte 0xD2 with txOutLast; txDone one cycle after handshake; txDataReady never high.
- DATA0 ZLP → bytes C3, 00, 00; last flagged on third byte.
- DATA1 payload ASCII "123456789", txOutReady always high → 4B, 31..39, C8, B4 over 12 consecutive cycles.
- Same DATA1 packet with txOutReady toggled pseudo-randomly → identical byte sequence, bytes stable while stalled, no duplicates or drops.
- txReqPid = IN token (1001) → txReqError pulse, no txOutValid. A second request issued mid-packet is ignored.
- rst asserted during SEND_DATA → outputs 0 next edge, no txDone. A following STALL request → 0x1E.
